csi2_packet_tx: RTL and testbench

Two-lane MIPI CSI-2 packet transmitter; the byte-level counterpart of our CSI-2 lane receiver.
Accepts frame and line commands plus a 16-bit payload stream and emits per-lane HS byte streams: SoT sync, packet header with ECC, payload, CRC-16, and trailer.
Sits between the sensor-emulation/pixel source and the D-PHY serializers. It is used for loopback and self-test of the receive path.

---
 rtl/csi2_packet_tx.sv | 227 ++++++++++++++++++++++
 tb/tb_csi2_packet_tx.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csi2_packet_tx.sv
`default_nettype none
// ============================================================================
// Module   : csi2_packet_tx
// Purpose  : Two-lane MIPI CSI-2 packet transmitter. Turns frame/line
//            commands plus a 16-bit payload stream into per-lane HS byte
//            streams: HS-zero prep, sync byte, header with ECC, payload,
//            CRC-16, trailer, then an LP gap before the next command.
// Ports    : byte_clk, reset (async, active high)
//            cmd_valid/cmd_ready/cmd_type/cmd_wc : command handshake
//            pld_data/pld_valid/pld_ready        : payload word stream
//            hs_req, byte_valid, lane0_byte, lane1_byte : to serializers
//            underrun_err, cmd_err               : sticky error flags
// Revision : 1.0 - initial release
// ============================================================================
module csi2_packet_tx #(
    parameter logic [1:0] VC      = 2'd0,
    parameter logic [5:0] DT_LONG = 6'h2B,
    parameter int         T_PREP  = 4,
    parameter int         T_TRAIL = 4,
    parameter int         T_GAP   = 8
) (
    input  logic        byte_clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_type,
    input  logic [15:0] cmd_wc,
    input  logic [15:0] pld_data,
    input  logic        pld_valid,
    output logic        pld_ready,
    output logic        hs_req,
    output logic        byte_valid,
    output logic [7:0]  lane0_byte,
    output logic [7:0]  lane1_byte,
    output logic        underrun_err,
    output logic        cmd_err
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_PREP  = 4'd1,
        S_SYNC  = 4'd2,
        S_HDR0  = 4'd3,
        S_HDR1  = 4'd4,
        S_PAY   = 4'd5,
        S_CRC   = 4'd6,
        S_TRAIL = 4'd7,
        S_GAP   = 4'd8
    } state_t;

    localparam logic [15:0] c_PREP_LAST  = 16'(T_PREP - 1);
    localparam logic [15:0] c_TRAIL_LAST = 16'(T_TRAIL - 1);
    localparam logic [15:0] c_GAP_LAST   = 16'(T_GAP - 1);

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_cnt;
    logic [5:0]  r_dt;
    logic [15:0] r_wc;
    logic        r_long;
    logic [15:0] r_crc;
    logic        r_last0;
    logic        r_last1;

    logic [15:0] w_wc_even;
    logic        w_is_long;
    logic        w_cmd_bad;
    logic [5:0]  w_dt;
    logic [7:0]  w_di;
    logic [7:0]  w_ecc;

    // 6-bit Hamming-style ECC over {WC, DI}; top two bits are always zero.
    function automatic logic [7:0] f_ecc(input logic [23:0] h);
        logic [7:0] e;
        e    = 8'h00;
        e[0] = h[0]^h[1]^h[2]^h[4]^h[5]^h[7]^h[10]^h[11]^h[13]^h[16]^h[20]^h[21]^h[22]^h[23];
        e[1] = h[0]^h[1]^h[3]^h[4]^h[6]^h[8]^h[10]^h[12]^h[14]^h[17]^h[20]^h[21]^h[22]^h[23];
        e[2] = h[0]^h[2]^h[3]^h[5]^h[6]^h[9]^h[11]^h[12]^h[15]^h[18]^h[20]^h[21]^h[22];
        e[3] = h[1]^h[2]^h[3]^h[7]^h[8]^h[9]^h[13]^h[14]^h[15]^h[19]^h[20]^h[21]^h[23];
        e[4] = (^h[9:4]) ^ (^h[19:16]) ^ h[20] ^ h[22] ^ h[23];
        e[5] = (^h[19:10]) ^ h[21] ^ h[22] ^ h[23];
        return e;
    endfunction

    // Reflected CRC-16 (0x8408), one byte consumed LSB first.
    function automatic logic [15:0] f_crc_byte(input logic [15:0] crc_in, input logic [7:0] b);
        logic [15:0] c;
        logic        fb;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            fb = c[0] ^ b[i];
            c  = {1'b0, c[15:1]};
            if (fb) c = c ^ 16'h8408;
        end
        return c;
    endfunction

    // Command decode: long commands carry an even byte count; an odd or
    // zero count is flagged, and zero degenerates to a short packet.
    assign w_wc_even = {cmd_wc[15:1], 1'b0};
    assign w_is_long = (cmd_type == 2'd2);
    assign w_cmd_bad = (cmd_type == 2'd3) || (w_is_long && (cmd_wc[0] || (w_wc_even == 16'h0000)));

    always_comb begin
        w_dt = 6'h00;
        case (cmd_type)
            2'd1:    w_dt = 6'h01;
            2'd2:    w_dt = DT_LONG;
            default: w_dt = 6'h00;
        endcase
    end

    assign w_di  = {VC, r_dt};
    assign w_ecc = f_ecc({r_wc, w_di});

    // Next-state and outputs. pld_ready is purely a function of state so the
    // source sees the consume strobe in the same cycle its word is on the lanes.
    always_comb begin
        w_next     = r_state;
        cmd_ready  = 1'b0;
        pld_ready  = 1'b0;
        hs_req     = 1'b0;
        byte_valid = 1'b0;
        lane0_byte = 8'h00;
        lane1_byte = 8'h00;
        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid && (cmd_type != 2'd3)) w_next = S_PREP;
            end
            S_PREP: begin
                hs_req = 1'b1;
                if (r_cnt == c_PREP_LAST) w_next = S_SYNC;
            end
            S_SYNC: begin
                hs_req     = 1'b1;
                byte_valid = 1'b1;
                lane0_byte = 8'hB8;
                lane1_byte = 8'hB8;
                w_next     = S_HDR0;
            end
            S_HDR0: begin
                hs_req     = 1'b1;
                byte_valid = 1'b1;
                lane0_byte = w_di;
                lane1_byte = r_wc[7:0];
                w_next     = S_HDR1;
            end
            S_HDR1: begin
                hs_req     = 1'b1;
                byte_valid = 1'b1;
                lane0_byte = r_wc[15:8];
                lane1_byte = w_ecc;
                w_next     = r_long ? S_PAY : S_TRAIL;
            end
            S_PAY: begin
                hs_req     = 1'b1;
                byte_valid = 1'b1;
                pld_ready  = 1'b1;
                // Starved cycles send zeros rather than stalling the HS burst.
                lane0_byte = pld_valid ? pld_data[7:0]  : 8'h00;
                lane1_byte = pld_valid ? pld_data[15:8] : 8'h00;
                if ((r_cnt + 16'd1) == {1'b0, r_wc[15:1]}) w_next = S_CRC;
            end
            S_CRC: begin
                hs_req     = 1'b1;
                byte_valid = 1'b1;
                lane0_byte = r_crc[7:0];
                lane1_byte = r_crc[15:8];
                w_next     = S_TRAIL;
            end
            S_TRAIL: begin
                hs_req     = 1'b1;
                lane0_byte = {8{~r_last0}};
                lane1_byte = {8{~r_last1}};
                if (r_cnt == c_TRAIL_LAST) w_next = S_GAP;
            end
            S_GAP: begin
                if (r_cnt == c_GAP_LAST) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge byte_clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= 16'h0000;
            r_dt         <= 6'h00;
            r_wc         <= 16'h0000;
            r_long       <= 1'b0;
            r_crc        <= 16'h0000;
            r_last0      <= 1'b0;
            r_last1      <= 1'b0;
            underrun_err <= 1'b0;
            cmd_err      <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_next != r_state) ? 16'h0000 : r_cnt + 16'd1;

            if (cmd_ready && cmd_valid) begin
                if (cmd_type != 2'd3) begin
                    r_dt   <= w_dt;
                    r_wc   <= w_is_long ? w_wc_even : cmd_wc;
                    r_long <= w_is_long && (w_wc_even != 16'h0000);
                end
                if (w_cmd_bad) cmd_err <= 1'b1;
            end

            if (r_state == S_HDR1) begin
                r_crc <= 16'hFFFF;
            end else if (r_state == S_PAY) begin
                r_crc <= f_crc_byte(f_crc_byte(r_crc, lane0_byte), lane1_byte);
            end

            // Remember the final bit on each lane; the trailer inverts it.
            if (byte_valid) begin
                r_last0 <= lane0_byte[7];
                r_last1 <= lane1_byte[7];
            end

            if ((r_state == S_PAY) && !pld_valid) underrun_err <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_csi2_packet_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_csi2_packet_tx
// Purpose  : Self-checking bench for csi2_packet_tx. Expected lane words are
//            queued when a command is issued and compared by a monitor on
//            every byte_valid cycle; scenario tasks add inline timing checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_csi2_packet_tx;

    logic        byte_clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_type;
    logic [15:0] cmd_wc;
    logic [15:0] pld_data;
    logic        pld_valid;
    logic        pld_ready;
    logic        hs_req;
    logic        byte_valid;
    logic [7:0]  lane0_byte;
    logic [7:0]  lane1_byte;
    logic        underrun_err;
    logic        cmd_err;

    int checks = 0;
    int errors = 0;
    int pld_cycles = 0;

    logic [15:0] exp_q[$];
    logic [15:0] pay_q[$];
    bit          val_q[$];

    csi2_packet_tx dut (
        .byte_clk     (byte_clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_type     (cmd_type),
        .cmd_wc       (cmd_wc),
        .pld_data     (pld_data),
        .pld_valid    (pld_valid),
        .pld_ready    (pld_ready),
        .hs_req       (hs_req),
        .byte_valid   (byte_valid),
        .lane0_byte   (lane0_byte),
        .lane1_byte   (lane1_byte),
        .underrun_err (underrun_err),
        .cmd_err      (cmd_err)
    );

    always #5 byte_clk = ~byte_clk;

    // ---------------- reference model ----------------
    function automatic logic [23:0] ecc_mask(input int k);
        case (k)
            0:       return 24'hF12CB7;
            1:       return 24'hF2555B;
            2:       return 24'h749A6D;
            3:       return 24'hB8E38E;
            4:       return 24'hDF03F0;
            default: return 24'hEFFC00;
        endcase
    endfunction

    function automatic logic [7:0] m_ecc(input logic [23:0] h);
        logic [7:0] e;
        e = 8'h00;
        for (int k = 0; k < 6; k++) e[k] = ^(h & ecc_mask(k));
        return e;
    endfunction

    function automatic logic [15:0] m_crc(input logic [15:0] c_in, input logic [7:0] b);
        logic [15:0] c;
        logic        lsb;
        c = c_in;
        for (int i = 0; i < 8; i++) begin
            lsb = c[0] ^ b[i];
            c   = c >> 1;
            if (lsb) c = c ^ 16'h8408;
        end
        return c;
    endfunction

    // Queue the expected lane words for one packet and the payload to feed it.
    task automatic push_packet(input logic [1:0] t, input logic [15:0] wc_raw,
                               input bit zero_pl, input int drop_idx);
        logic [15:0] wc;
        logic [7:0]  di;
        logic [15:0] crc;
        logic [15:0] w;
        bit          v;
        wc = (t == 2'd2) ? {wc_raw[15:1], 1'b0} : wc_raw;
        di = (t == 2'd0) ? 8'h00 : (t == 2'd1) ? 8'h01 : 8'h2B;
        exp_q.push_back(16'hB8B8);
        exp_q.push_back({wc[7:0], di});
        exp_q.push_back({m_ecc({wc, di}), wc[15:8]});
        if (t == 2'd2 && wc != 16'h0000) begin
            crc = 16'hFFFF;
            for (int i = 0; i < int'(wc) / 2; i++) begin
                w = zero_pl ? 16'h0000 : 16'($urandom);
                v = (i != drop_idx);
                pay_q.push_back(w);
                val_q.push_back(v);
                if (!v) w = 16'h0000;
                exp_q.push_back(w);
                crc = m_crc(m_crc(crc, w[7:0]), w[15:8]);
            end
            exp_q.push_back(crc);
        end
    endtask

    // ---------------- payload source ----------------
    initial begin
        pld_data  = 16'h0000;
        pld_valid = 1'b0;
        forever begin
            @(posedge byte_clk);
            #1;
            if (pld_ready && pay_q.size() > 0) begin
                pld_data  = pay_q.pop_front();
                pld_valid = val_q.pop_front();
            end else begin
                pld_data  = 16'h0000;
                pld_valid = 1'b0;
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge byte_clk) begin
        logic [15:0] exp_w;
        if (!reset) begin
            if (pld_ready) pld_cycles++;
            if (byte_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL stream: got lanes %h/%h, expected no byte_valid", lane0_byte, lane1_byte);
                end else begin
                    exp_w = exp_q.pop_front();
                    if ({lane1_byte, lane0_byte} !== exp_w) begin
                        errors++;
                        $display("FAIL stream: got lane0/lane1 %h/%h, expected %h/%h",
                                 lane0_byte, lane1_byte, exp_w[7:0], exp_w[15:8]);
                    end
                end
            end
        end
    end

    // ---------------- helpers (stimulus only) ----------------
    task automatic issue_cmd(input logic [1:0] t, input logic [15:0] wc);
        bit ok;
        ok = 1'b0;
        @(posedge byte_clk);
        #1;
        cmd_valid = 1'b1;
        cmd_type  = t;
        cmd_wc    = wc;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge byte_clk);
            if (cmd_ready) begin
                @(posedge byte_clk);
                #1;
                ok = 1'b1;
            end
        end
        cmd_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL cmd_accept: cmd_ready never seen, got 0 expected 1");
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge byte_clk);
            if (cmd_ready) ok = 1'b1;
        end
        checks++;
        if (!ok || exp_q.size() != 0) begin
            errors++;
            $display("FAIL packet_done: idle=%0d pending=%0d, expected idle=1 pending=0", ok, exp_q.size());
        end
    endtask

    task automatic reset_dut();
        @(posedge byte_clk);
        #3;
        reset = 1'b1;
        exp_q.delete();
        pay_q.delete();
        val_q.delete();
        repeat (2) @(posedge byte_clk);
        #3;
        reset = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_dut();
        @(negedge byte_clk);
        checks++;
        if ({cmd_ready, pld_ready, hs_req, byte_valid, underrun_err, cmd_err, lane0_byte, lane1_byte}
                !== {1'b1, 5'b0, 16'h0000}) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b pr=%b hs=%b bv=%b ue=%b ce=%b l0=%h l1=%h, expected rdy=1 rest 0",
                     cmd_ready, pld_ready, hs_req, byte_valid, underrun_err, cmd_err, lane0_byte, lane1_byte);
        end
    endtask

    task automatic test_fs_timing();
        logic [18:0] exp_v;
        push_packet(2'd0, 16'h0000, 1'b0, -1);
        issue_cmd(2'd0, 16'h0000);
        for (int k = 1; k <= 20; k++) begin
            @(negedge byte_clk);
            if (k <= 4)       exp_v = {1'b1, 1'b0, 8'h00, 8'h00, 1'b0};
            else if (k == 5)  exp_v = {1'b1, 1'b1, 8'hB8, 8'hB8, 1'b0};
            else if (k <= 7)  exp_v = {1'b1, 1'b1, 8'h00, 8'h00, 1'b0};
            else if (k <= 11) exp_v = {1'b1, 1'b0, 8'hFF, 8'hFF, 1'b0};
            else if (k <= 19) exp_v = {1'b0, 1'b0, 8'h00, 8'h00, 1'b0};
            else              exp_v = {1'b0, 1'b0, 8'h00, 8'h00, 1'b1};
            checks++;
            if ({hs_req, byte_valid, lane0_byte, lane1_byte, cmd_ready} !== exp_v) begin
                errors++;
                $display("FAIL fs_timing cycle %0d: got hs=%b bv=%b l0=%h l1=%h rdy=%b, expected hs=%b bv=%b l0=%h l1=%h rdy=%b",
                         k, hs_req, byte_valid, lane0_byte, lane1_byte, cmd_ready,
                         exp_v[18], exp_v[17], exp_v[16:9], exp_v[8:1], exp_v[0]);
            end
        end
    endtask

    task automatic test_long_wc2();
        logic [15:0] got [4];
        logic [15:0] req [4];
        req = '{16'h022B, 16'h0B00, 16'h0000, 16'hF0B8};
        push_packet(2'd2, 16'h0002, 1'b1, -1);
        issue_cmd(2'd2, 16'h0002);
        repeat (5) @(negedge byte_clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge byte_clk);
            got[k] = {lane1_byte, lane0_byte};
        end
        @(negedge byte_clk);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (got[k] !== req[k]) begin
                errors++;
                $display("FAIL long_wc2 word %0d: got l0/l1 %h/%h, expected %h/%h",
                         k, got[k][7:0], got[k][15:8], req[k][7:0], req[k][15:8]);
            end
        end
        // CRC bytes both end in bit7=1, so the trailer drives zeros.
        checks++;
        if ({hs_req, byte_valid, lane0_byte, lane1_byte} !== {2'b10, 16'h0000}) begin
            errors++;
            $display("FAIL long_wc2 trail: got hs=%b bv=%b l0=%h l1=%h, expected hs=1 bv=0 00/00",
                     hs_req, byte_valid, lane0_byte, lane1_byte);
        end
        wait_idle();
    endtask

    task automatic test_long_800();
        pld_cycles = 0;
        push_packet(2'd2, 16'h0640, 1'b0, -1);
        issue_cmd(2'd2, 16'h0640);
        repeat (6) @(negedge byte_clk);
        checks++;
        if ({lane0_byte, lane1_byte} !== 16'h2B40) begin
            errors++;
            $display("FAIL long800 hdr0: got %h/%h expected 2b/40", lane0_byte, lane1_byte);
        end
        @(negedge byte_clk);
        checks++;
        if ({lane0_byte, lane1_byte, pld_ready} !== {16'h063B, 1'b0}) begin
            errors++;
            $display("FAIL long800 hdr1: got %h/%h pr=%b expected 06/3b pr=0", lane0_byte, lane1_byte, pld_ready);
        end
        wait_idle();
        checks++;
        if (pld_cycles != 800) begin
            errors++;
            $display("FAIL long800 pld_ready cycles: got %0d expected 800", pld_cycles);
        end
        checks++;
        if (underrun_err !== 1'b0) begin
            errors++;
            $display("FAIL long800 underrun_err: got %b expected 0", underrun_err);
        end
    endtask

    task automatic test_underrun();
        push_packet(2'd2, 16'h0008, 1'b0, 1);
        issue_cmd(2'd2, 16'h0008);
        wait_idle();
        checks++;
        if ({underrun_err, cmd_err} !== 2'b10) begin
            errors++;
            $display("FAIL underrun: got ue=%b ce=%b expected ue=1 ce=0", underrun_err, cmd_err);
        end
        push_packet(2'd1, 16'h0007, 1'b0, -1);
        issue_cmd(2'd1, 16'h0007);
        wait_idle();
        checks++;
        if (underrun_err !== 1'b1) begin
            errors++;
            $display("FAIL underrun sticky: got %b expected 1", underrun_err);
        end
    endtask

    task automatic test_odd_wc();
        pld_cycles = 0;
        push_packet(2'd2, 16'h0003, 1'b0, -1);
        issue_cmd(2'd2, 16'h0003);
        wait_idle();
        checks++;
        if (cmd_err !== 1'b1 || pld_cycles != 1) begin
            errors++;
            $display("FAIL odd_wc: got ce=%b pay_cycles=%0d expected ce=1 pay_cycles=1", cmd_err, pld_cycles);
        end
    endtask

    task automatic test_reset_mid_pay();
        push_packet(2'd2, 16'h0040, 1'b0, -1);
        issue_cmd(2'd2, 16'h0040);
        repeat (12) @(negedge byte_clk);
        @(posedge byte_clk);
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if ({hs_req, byte_valid, pld_ready, cmd_ready, underrun_err, cmd_err} !== 6'b000100) begin
            errors++;
            $display("FAIL reset_mid_pay: got hs=%b bv=%b pr=%b rdy=%b ue=%b ce=%b expected 0 0 0 1 0 0",
                     hs_req, byte_valid, pld_ready, cmd_ready, underrun_err, cmd_err);
        end
        exp_q.delete();
        pay_q.delete();
        val_q.delete();
        repeat (2) @(posedge byte_clk);
        #3;
        reset = 1'b0;
        push_packet(2'd0, 16'h0005, 1'b0, -1);
        issue_cmd(2'd0, 16'h0005);
        wait_idle();
    endtask

    task automatic test_reserved_type();
        issue_cmd(2'd3, 16'h1234);
        for (int k = 0; k < 8; k++) begin
            @(negedge byte_clk);
            checks++;
            if ({hs_req, cmd_ready} !== 2'b01) begin
                errors++;
                $display("FAIL reserved_type cycle %0d: got hs=%b rdy=%b expected hs=0 rdy=1", k, hs_req, cmd_ready);
            end
        end
        checks++;
        if (cmd_err !== 1'b1) begin
            errors++;
            $display("FAIL reserved_type cmd_err: got %b expected 1", cmd_err);
        end
    endtask

    task automatic test_long_zero_wc();
        pld_cycles = 0;
        push_packet(2'd2, 16'h0001, 1'b0, -1);
        issue_cmd(2'd2, 16'h0001);
        wait_idle();
        checks++;
        if (cmd_err !== 1'b1 || pld_cycles != 0) begin
            errors++;
            $display("FAIL long_zero_wc: got ce=%b pay_cycles=%0d expected ce=1 pay_cycles=0", cmd_err, pld_cycles);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  t;
        logic [15:0] wc;
        for (int n = 0; n < 5; n++) begin
            t  = 2'($urandom_range(0, 2));
            wc = 16'($urandom_range(1, 20) * 2);
            push_packet(t, wc, 1'b0, -1);
            issue_cmd(t, wc);
        end
        wait_idle();
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_type  = 2'd0;
        cmd_wc    = 16'h0000;
        test_reset();
        test_fs_timing();
        test_long_wc2();
        test_long_800();
        test_underrun();
        test_odd_wc();
        test_reset_mid_pay();
        test_reserved_type();
        reset_dut();
        test_long_zero_wc();
        reset_dut();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
